ps2_rx_fifo: RTL and testbench

- Parametrised receiver for the PS/2-style serial frame used by our keyboard/tap bench.
- Frame format: idle-high serial clock; data changes while the clock is high and is sampled on the falling edge; start bit 0; DATA_BITS data bits LSB first; optional parity bit; stop bit 1.
- Oversamples the serial lines in the system clock domain, deglitches them, decodes frames with error checking and a mid-frame timeout, and buffers decoded words plus per-word error flags in a small FIFO behind a valid/ready interface.
- Successor to the fixed 8-bit, odd-parity, single-word receiver: width, parity mode, filtering, timeout and buffer depth are now parameters.

---
 rtl/ps2_rx_fifo.sv | 162 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2-style serial frame receiver: synchronise and deglitch sclk/sdat, decode
// start/data/parity/stop on filtered sclk falling edges, queue words in a FIFO.
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 4,
  parameter int TIMEOUT     = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sclk,
  input  logic                          sdat,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_perr,
  output logic                          out_ferr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int PW = LW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FILTER + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, sdat_sync;
  logic [1:0]             raw, filt;
  logic [FW-1:0]          fcnt [2];
  logic                   sclk_prev, stb, sd;
  state_t                 state, state_next;
  logic                   tout_hit, frame_done;
  logic [TW-1:0]          tcnt;
  logic [BW-1:0]          bcnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_r, push_pend;
  logic [EW-1:0]          push_word;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          wptr, rptr;
  logic                   full, pop, do_push;

  // Lines idle high, so synchronisers and filters reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '1;
      sdat_sync <= '1;
      filt      <= 2'b11;
      sclk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], sdat};
      sclk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign raw = {sdat_sync[SYNC_STAGES-1], sclk_sync[SYNC_STAGES-1]};
  assign stb = sclk_prev & ~filt[0];
  assign sd  = filt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A strobe in the same cycle as the timeout limit wins: it proves the sender is alive.
  always_comb begin
    state_next = state;
    tout_hit   = 1'b0;
    frame_done = 1'b0;
    if (stb) begin
      case (state)
        IDLE: if (!sd) state_next = DATA;
        DATA: if (bcnt == BW'(DATA_BITS - 1)) state_next = (PARITY == 0) ? STOP : PAR;
        PAR:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
      state_next = IDLE;
      tout_hit   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      perr_r    <= 1'b0;
      push_pend <= 1'b0;
      push_word <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout   <= tout_hit;
      push_pend <= frame_done;
      if (stb || state == IDLE || tout_hit) tcnt <= '0;
      else                                  tcnt <= tcnt + TW'(1);
      if (stb) begin
        case (state)
          IDLE: begin
            bcnt   <= '0;
            shreg  <= '0;
            perr_r <= 1'b0;
          end
          DATA: begin
            shreg <= (shreg >> 1) | (DATA_BITS'(sd) << (DATA_BITS - 1));
            bcnt  <= bcnt + BW'(1);
          end
          PAR:  perr_r <= (PARITY == 1) ? ~(^shreg ^ sd) : (^shreg ^ sd);
          STOP: push_word <= {shreg, perr_r, ~sd};
          default: ;
        endcase
      end
    end
  end

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign level     = wptr - rptr;
  assign full      = (level == PW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign do_push   = push_pend & (~full | pop);
  assign {out_data, out_perr, out_ferr} = mem[rptr[LW-1:0]];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overflow <= push_pend & full & ~pop;
      if (do_push) begin
        mem[wptr[LW-1:0]] <= push_word;
        wptr <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed and random frames against a queue-based
// reference model; a second instance covers 9-bit frames without parity.
module tb_ps2_rx_fifo;
  localparam int HALF = 20;
  localparam int LAT  = 2 + 4 + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk, sdat, out_ready;
  logic [7:0] out_data;
  logic       out_perr, out_ferr, out_valid, overflow, timeout, busy;
  logic [2:0] level;

  logic       sclk2, sdat2, out_ready2;
  logic [8:0] out_data2;
  logic       out_perr2, out_ferr2, out_valid2, overflow2, timeout2, busy2;
  logic [2:0] level2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fall = 0;
  int lat_arm = 0;
  int ovf_cnt = 0;
  int to_cnt = 0;
  int exp_ovf = 0;
  logic [9:0] exp_q[$];
  logic       prev_hold = 1'b0;
  logic [9:0] prev_word;

  ps2_rx_fifo dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .sdat(sdat),
    .out_data(out_data), .out_perr(out_perr), .out_ferr(out_ferr),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .timeout(timeout), .busy(busy), .level(level)
  );

  ps2_rx_fifo #(.DATA_BITS(9), .PARITY(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk2), .sdat(sdat2),
    .out_data(out_data2), .out_perr(out_perr2), .out_ferr(out_ferr2),
    .out_valid(out_valid2), .out_ready(out_ready2), .overflow(overflow2),
    .timeout(timeout2), .busy(busy2), .level(level2)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every pop is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      if (overflow) ovf_cnt++;
      if (timeout)  to_cnt++;
      if (prev_hold) begin
        total++;
        assert ({out_valid, out_data, out_perr, out_ferr} === {1'b1, prev_word})
        else begin
          bad++;
          $error("FAIL hold_stable got=%0h exp=%0h", {out_valid, out_data, out_perr, out_ferr}, {1'b1, prev_word});
        end
      end
      if (out_valid && out_ready) begin
        if (lat_arm != 0) begin
          lat_arm = 0;
          total++;
          assert (cyc - last_fall <= LAT)
          else begin
            bad++;
            $error("FAIL latency got=%0d exp<=%0d", cyc - last_fall, LAT);
          end
        end
        total++;
        assert (exp_q.size() > 0)
        else begin
          bad++;
          $error("FAIL unexpected_pop got=%0h exp=none", {out_data, out_perr, out_ferr});
        end
        if (exp_q.size() > 0) begin
          logic [9:0] e;
          e = exp_q.pop_front();
          total++;
          assert ({out_data, out_perr, out_ferr} === e)
          else begin
            bad++;
            $error("FAIL pop_word got=%0h exp=%0h", {out_data, out_perr, out_ferr}, e);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_data, out_perr, out_ferr};
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_clk(input int which, input logic v);
    if (which == 0) sclk = v;
    else            sclk2 = v;
  endtask

  task automatic set_dat(input int which, input logic v);
    if (which == 0) sdat = v;
    else            sdat2 = v;
  endtask

  // Sends n bits LSB first; on bit glitch_bit, adds a 1-cycle sclk glitch in both phases.
  task automatic send_bits(input int which, input logic [31:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      set_dat(which, bits[i]);
      if (i == glitch_bit) begin
        repeat (5) tick();
        set_clk(which, 1'b0);
        tick();
        set_clk(which, 1'b1);
        repeat (HALF - 6) tick();
      end else begin
        repeat (HALF) tick();
      end
      set_clk(which, 1'b0);
      last_fall = cyc;
      if (i == glitch_bit) begin
        repeat (8) tick();
        set_clk(which, 1'b1);
        tick();
        set_clk(which, 1'b0);
        repeat (HALF - 9) tick();
      end else begin
        repeat (HALF) tick();
      end
      set_clk(which, 1'b1);
      repeat (2) tick();
    end
  endtask

  // Reference model: odd parity means the data ones plus the parity bit total an odd count.
  task automatic model_push(input logic [7:0] d, input logic pbit, input logic stopb);
    logic perr;
    perr = ((($countones(d) + int'(pbit)) % 2) != 1);
    if (exp_q.size() >= 4) exp_ovf++;
    else                   exp_q.push_back({d, perr, ~stopb});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input int glitch_bit);
    model_push(d, pbit, stopb);
    send_bits(0, {21'd0, stopb, pbit, d, 1'b0}, 11, glitch_bit);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Stimulus
  initial begin
    logic [7:0] d;
    reset_n = 1'b0;
    sclk = 1'b1; sdat = 1'b1; out_ready = 1'b0;
    sclk2 = 1'b1; sdat2 = 1'b1; out_ready2 = 1'b0;
    repeat (5) tick();
    check("reset_outs", {out_valid, level, busy, out_data, out_perr, out_ferr, overflow, timeout}, 0);
    check("reset_outs2", {out_valid2, level2, busy2, out_data2, out_perr2, out_ferr2, overflow2, timeout2}, 0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Single 0xA5 frame with latency bound
    out_ready = 1'b1;
    lat_arm = 1;
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    wait_drain("drain_a5");
    check("latency_seen", lat_arm, 0);

    // 16 random bytes with correct odd parity
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ~^d, 1'b1, -1);
    end
    wait_drain("drain_rand");
    check("no_flags_rand", {ovf_cnt[7:0], to_cnt[7:0]}, 0);

    // Parity error then framing error
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    wait_drain("drain_err");

    // Overflow with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), ~^8'(i), 1'b1, -1);
    repeat (10) tick();
    check("full_level", level, 4);
    check("ovf_count", ovf_cnt, exp_ovf);
    check("head_word", {out_valid, out_data}, {1'b1, 8'h01});
    out_ready = 1'b1;
    wait_drain("drain_ovf");

    // Timeout after start + 3 data bits
    send_bits(0, 32'b1010, 4, -1);
    check("busy_mid", busy, 1);
    repeat (2100) tick();
    check("timeout_pulse", to_cnt, 1);
    check("busy_after_to", {busy, out_valid}, 0);
    send_frame(8'h5A, ~^8'h5A, 1'b1, -1);
    wait_drain("drain_5a");

    // Glitches shorter than the filter, idle and mid-frame
    sclk = 1'b0;
    tick();
    sclk = 1'b1;
    repeat (10) tick();
    check("idle_glitch", busy, 0);
    send_frame(8'hC3, ~^8'hC3, 1'b1, 4);
    wait_drain("drain_c3");

    // Reset mid-frame discards the partial frame
    send_bits(0, 32'b10110, 5, -1);
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_mid", {busy, level}, 0);
    reset_n = 1'b1;
    repeat (5) tick();
    send_frame(8'h77, ~^8'h77, 1'b1, -1);
    wait_drain("drain_77");

    // 9-bit, no-parity instance
    send_bits(1, {21'd0, 1'b1, 9'h1FF, 1'b0}, 11, -1);
    repeat (5) tick();
    check("w9_word", {out_valid2, level2, out_data2, out_perr2, out_ferr2}, {1'b1, 3'd1, 9'h1FF, 2'b00});
    send_bits(1, {21'd0, 1'b1, 9'h12B, 1'b0}, 11, -1);
    repeat (5) tick();
    check("w9_level", level2, 2);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("w9_second", {out_valid2, out_data2, out_perr2, out_ferr2}, {1'b1, 9'h12B, 2'b00});
    check("w9_flags", {overflow2, timeout2, busy2}, 0);

    check("final_ovf", ovf_cnt, exp_ovf);
    check("final_to", to_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
